// File: rtl/uart_isp_pkg.sv
// Shared definitions for the CoreUART access sequencer: FSM encoding, error bit
// positions and the active level of the core's register strobes.
package uart_isp_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WR_STB = 2'd1,
      ST_WR_GAP = 2'd2,
      ST_RD_STB = 2'd3
   } seq_state_e;

   localparam int ERR_OVF = 0;
   localparam int ERR_PAR = 1;
   localparam int ERR_FRM = 2;

   localparam logic STB_ON  = 1'b0;
   localparam logic STB_OFF = 1'b1;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/uart_access_sequencer_if.sv
// Bundle of requester streams, RX output register, error flags and CoreUART pins.
// master = sequencer side, slave = requesters plus UART core wrapper.
interface uart_access_sequencer_if;

   logic [7:0]  a_tx_data;
   logic        a_tx_valid;
   logic        a_tx_ready;
   logic [7:0]  b_tx_data;
   logic        b_tx_valid;
   logic        b_tx_ready;

   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;

   logic [2:0]  err_flags;
   logic        err_clr;

   logic [7:0]  uart_data_in;
   logic [7:0]  uart_data_out;
   logic        uart_csn;
   logic        uart_wen;
   logic        uart_oen;
   logic        uart_txrdy;
   logic        uart_rxrdy;
   logic        uart_framing_err;
   logic        uart_parity_err;
   logic        uart_overflow;

   logic [12:0] uart_baud_val;
   logic        uart_bit8;
   logic        uart_parity_en;
   logic        uart_odd_n_even;

   modport master (
      input  a_tx_data, a_tx_valid, b_tx_data, b_tx_valid, rx_ready, err_clr,
      input  uart_data_out, uart_txrdy, uart_rxrdy,
      input  uart_framing_err, uart_parity_err, uart_overflow,
      output a_tx_ready, b_tx_ready, rx_data, rx_valid, err_flags,
      output uart_data_in, uart_csn, uart_wen, uart_oen,
      output uart_baud_val, uart_bit8, uart_parity_en, uart_odd_n_even
   );

   modport slave (
      output a_tx_data, a_tx_valid, b_tx_data, b_tx_valid, rx_ready, err_clr,
      output uart_data_out, uart_txrdy, uart_rxrdy,
      output uart_framing_err, uart_parity_err, uart_overflow,
      input  a_tx_ready, b_tx_ready, rx_data, rx_valid, err_flags,
      input  uart_data_in, uart_csn, uart_wen, uart_oen,
      input  uart_baud_val, uart_bit8, uart_parity_en, uart_odd_n_even
   );

endinterface

// File: rtl/uart_rr_arb2.sv
// Two-way round-robin arbiter. ptr=0 prefers requester 0; after a taken grant
// the preference moves to the requester that was not granted.
module uart_rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       take,
   output logic [1:0] gnt
);

   logic ptr;

   always_comb begin
      gnt = 2'b00;
      if (!ptr) begin
         gnt[0] = req[0];
         gnt[1] = req[1] & ~req[0];
      end else begin
         gnt[1] = req[1];
         gnt[0] = req[0] & ~req[1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr <= 1'b0;
      end else if (take) begin
         ptr <= gnt[0];
      end
   end

endmodule

// File: rtl/uart_access_sequencer.sv
// Drives the CoreUART CSN/WEN/OEN register handshake for two TX byte streams and
// one buffered RX stream; also holds sticky error flags and static line config.
//
//  state   | meaning
//  --------+---------------------------------------------------------------
//  IDLE    | strobes high; pick a read (priority) or an arbitrated write
//  WR_STB  | CSN/WEN low one cycle, DATA_IN holds the granted byte
//  WR_GAP  | strobes high for WR_GAP cycles so TXRDY can settle
//  RD_STB  | CSN/OEN low RD_CYC cycles, DATA_OUT captured in the last one
module uart_access_sequencer
   import uart_isp_pkg::*;
#(
   parameter logic [12:0] BAUD_VAL_P  = 13'd1,
   parameter bit          BIT8_P      = 1'b1,
   parameter bit          PARITY_EN_P = 1'b0,
   parameter bit          ODD_EVEN_P  = 1'b0,
   parameter int          RD_CYC      = 2,
   parameter int          WR_GAP      = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   uart_access_sequencer_if.master   bus
);

   localparam logic [1:0] S_IDLE   = ST_IDLE;
   localparam logic [1:0] S_WR_STB = ST_WR_STB;
   localparam logic [1:0] S_WR_GAP = ST_WR_GAP;
   localparam logic [1:0] S_RD_STB = ST_RD_STB;

   localparam int CNT_MAX = max2(RD_CYC, WR_GAP);
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] RD_LOAD  = CNT_W'(RD_CYC - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(WR_GAP - 1);

   logic [1:0]       state;
   logic [CNT_W-1:0] cnt;
   logic             cnt_tc;

   logic             rd_req;
   logic             wr_take;
   logic [1:0]       req;
   logic [1:0]       gnt;

   logic [7:0]       data_in_q;
   logic [7:0]       rx_data_q;
   logic             rx_valid_q;
   logic [2:0]       err_q;
   logic [2:0]       err_set;

   assign cnt_tc = (cnt == '0);
   assign req    = {bus.b_tx_valid, bus.a_tx_valid};

   // Reset also masks the accept pulses, since the state register already reads IDLE.
   assign rd_req  = !rst && (state == S_IDLE) && bus.uart_rxrdy && !rx_valid_q;
   assign wr_take = !rst && (state == S_IDLE) && !rd_req && bus.uart_txrdy && (|req);

   uart_rr_arb2 u_arb (
      .clk  (clk),
      .rst  (rst),
      .req  (req),
      .take (wr_take),
      .gnt  (gnt)
   );

   assign bus.a_tx_ready = wr_take & gnt[0];
   assign bus.b_tx_ready = wr_take & gnt[1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (rd_req) begin
                  state <= S_RD_STB;
                  cnt   <= RD_LOAD;
               end else if (wr_take) begin
                  state <= S_WR_STB;
               end
            end
            S_WR_STB: begin
               state <= S_WR_GAP;
               cnt   <= GAP_LOAD;
            end
            S_WR_GAP: begin
               if (cnt_tc) begin
                  state <= S_IDLE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            S_RD_STB: begin
               if (cnt_tc) begin
                  state <= S_IDLE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: begin
               state <= S_IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_in_q <= 8'h00;
      end else if (wr_take) begin
         data_in_q <= gnt[0] ? bus.a_tx_data : bus.b_tx_data;
      end
   end

   // Capture only happens with rx_valid low, so it never races the consumer's clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_data_q  <= 8'h00;
         rx_valid_q <= 1'b0;
      end else if ((state == S_RD_STB) && cnt_tc) begin
         rx_data_q  <= bus.uart_data_out;
         rx_valid_q <= 1'b1;
      end else if (rx_valid_q && bus.rx_ready) begin
         rx_valid_q <= 1'b0;
      end
   end

   always_comb begin
      err_set          = 3'b000;
      err_set[ERR_OVF] = bus.uart_overflow;
      err_set[ERR_PAR] = bus.uart_parity_err;
      err_set[ERR_FRM] = bus.uart_framing_err;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_q <= 3'b000;
      end else begin
         err_q <= (err_q & ~{3{bus.err_clr}}) | err_set;
      end
   end

   // Strobes decode straight from the state flops so reset releases them asynchronously.
   assign bus.uart_wen = (state == S_WR_STB) ? STB_ON : STB_OFF;
   assign bus.uart_oen = (state == S_RD_STB) ? STB_ON : STB_OFF;
   assign bus.uart_csn = ((state == S_WR_STB) || (state == S_RD_STB)) ? STB_ON : STB_OFF;

   assign bus.uart_data_in = data_in_q;
   assign bus.rx_data      = rx_data_q;
   assign bus.rx_valid     = rx_valid_q;
   assign bus.err_flags    = err_q;

   assign bus.uart_baud_val   = BAUD_VAL_P;
   assign bus.uart_bit8       = BIT8_P;
   assign bus.uart_parity_en  = PARITY_EN_P;
   assign bus.uart_odd_n_even = ODD_EVEN_P;

endmodule

// File: tb/tb_uart_access_sequencer.sv
// Bench for uart_access_sequencer: directed handshake scenarios plus randomized
// TX arbitration and RX rounds against a transaction-level reference model.
module tb_uart_access_sequencer;

   localparam logic [12:0] BAUD = 13'd26;
   localparam int RDC = 2;
   localparam int GAP = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   uart_access_sequencer_if bus ();

   uart_access_sequencer #(
      .BAUD_VAL_P  (BAUD),
      .BIT8_P      (1'b1),
      .PARITY_EN_P (1'b1),
      .ODD_EVEN_P  (1'b0),
      .RD_CYC      (RDC),
      .WR_GAP      (GAP)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Core-side observer: bytes written, read-strobe cycles, strobe legality.
   logic [7:0] wr_log[$];
   int oen_cyc = 0;
   int strobe_bad = 0;

   always @(posedge clk) begin
      if (!bus.uart_csn && !bus.uart_wen) wr_log.push_back(bus.uart_data_in);
      if (!bus.uart_oen) oen_cyc <= oen_cyc + 1;
      if ((!bus.uart_wen && !bus.uart_oen) || (bus.uart_csn !== (bus.uart_wen & bus.uart_oen)))
         strobe_bad <= strobe_bad + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_inputs();
      bus.a_tx_data = 8'h00; bus.a_tx_valid = 1'b0;
      bus.b_tx_data = 8'h00; bus.b_tx_valid = 1'b0;
      bus.rx_ready = 1'b0;   bus.err_clr = 1'b0;
      bus.uart_data_out = 8'h00;
      bus.uart_txrdy = 1'b0; bus.uart_rxrdy = 1'b0;
      bus.uart_framing_err = 1'b0; bus.uart_parity_err = 1'b0; bus.uart_overflow = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clear_inputs();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   // Core presents a byte; RXRDY drops once the read strobe is seen.
   task automatic rx_once(input logic [7:0] d, output logic [7:0] got, output bit ok);
      bus.uart_data_out = d;
      bus.uart_rxrdy = 1'b1;
      ok = 1'b0;
      got = 8'h00;
      for (int i = 0; i < 12 && !ok; i++) begin
         @(negedge clk); #1;
         if (!bus.uart_oen) bus.uart_rxrdy = 1'b0;
         if (bus.rx_valid) begin
            ok = 1'b1;
            got = bus.rx_data;
         end
      end
      bus.uart_rxrdy = 1'b0;
   endtask

   task automatic rx_consume();
      bus.rx_ready = 1'b1;
      @(negedge clk); #1;
      chk("rx_consume", bus.rx_valid, 1'b0);
      bus.rx_ready = 1'b0;
   endtask

   logic [7:0] got;
   bit ok;
   int base;
   int rd_idx, rdy_idx;
   int pref, exp_id, got_id, m;
   logic [7:0] da, db, exp_byte;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      clear_inputs();
      rst = 1'b1;
      bus.a_tx_valid = 1'b1;
      bus.uart_txrdy = 1'b1;
      repeat (2) @(negedge clk); #1;
      chk("rst_csn", bus.uart_csn, 1'b1);
      chk("rst_wen", bus.uart_wen, 1'b1);
      chk("rst_oen", bus.uart_oen, 1'b1);
      chk("rst_data_in", bus.uart_data_in, 8'h00);
      chk("rst_rx_valid", bus.rx_valid, 1'b0);
      chk("rst_rx_data", bus.rx_data, 8'h00);
      chk("rst_err", bus.err_flags, 3'b000);
      chk("rst_a_ready", bus.a_tx_ready, 1'b0);
      chk("rst_b_ready", bus.b_tx_ready, 1'b0);
      chk("cfg_baud", bus.uart_baud_val, BAUD);
      chk("cfg_bit8", bus.uart_bit8, 1'b1);
      chk("cfg_par_en", bus.uart_parity_en, 1'b1);
      chk("cfg_odd", bus.uart_odd_n_even, 1'b0);
      bus.a_tx_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Single write from A, then gap length before the next accept.
      base = wr_log.size();
      bus.uart_txrdy = 1'b1;
      bus.a_tx_data = 8'h5A; bus.a_tx_valid = 1'b1;
      #1;
      chk("t1_a_ready", bus.a_tx_ready, 1'b1);
      chk("t1_b_ready", bus.b_tx_ready, 1'b0);
      chk("t1_csn_idle", bus.uart_csn, 1'b1);
      @(negedge clk);
      bus.a_tx_valid = 1'b0;
      #1;
      chk("t1_csn", bus.uart_csn, 1'b0);
      chk("t1_wen", bus.uart_wen, 1'b0);
      chk("t1_oen", bus.uart_oen, 1'b1);
      chk("t1_data_in", bus.uart_data_in, 8'h5A);
      @(negedge clk); #1;
      chk("t1_wen_one_cyc", bus.uart_wen, 1'b1);
      chk("t1_csn_off", bus.uart_csn, 1'b1);
      bus.a_tx_data = 8'hA5; bus.a_tx_valid = 1'b1;
      #1;
      chk("t1_gap_start", bus.a_tx_ready, 1'b0);
      repeat (GAP - 1) @(negedge clk);
      #1;
      chk("t1_gap_end", bus.a_tx_ready, 1'b0);
      @(negedge clk); #1;
      chk("t1_gap_done", bus.a_tx_ready, 1'b1);
      @(negedge clk);
      bus.a_tx_valid = 1'b0;
      repeat (GAP + 2) @(negedge clk);
      chk("t1_wr_count", wr_log.size() - base, 2);
      if (wr_log.size() >= base + 2) begin
         chk("t1_wr0", wr_log[base], 8'h5A);
         chk("t1_wr1", wr_log[base + 1], 8'hA5);
      end

      // Both requesters streaming: grants alternate starting with A.
      do_reset();
      base = wr_log.size();
      bus.uart_txrdy = 1'b1;
      bus.a_tx_data = 8'h11; bus.a_tx_valid = 1'b1;
      bus.b_tx_data = 8'h22; bus.b_tx_valid = 1'b1;
      for (int i = 0; i < 60 && wr_log.size() < base + 4; i++) @(negedge clk);
      bus.a_tx_valid = 1'b0; bus.b_tx_valid = 1'b0;
      chk("t2_wr_count", (wr_log.size() >= base + 4), 1'b1);
      for (int i = 0; i < 4; i++) begin
         if (wr_log.size() > base + i) chk("t2_alt", wr_log[base + i], (i % 2 == 0) ? 8'h11 : 8'h22);
      end
      repeat (GAP + 2) @(negedge clk);

      // Random arbitration rounds against a round-robin reference model.
      do_reset();
      pref = 0;
      bus.uart_txrdy = 1'b1;
      for (int r = 0; r < 16; r++) begin
         m  = $urandom_range(1, 3);
         da = 8'($urandom_range(0, 255));
         db = 8'($urandom_range(0, 255));
         exp_id = (m == 3) ? pref : ((m == 1) ? 0 : 1);
         exp_byte = (exp_id == 0) ? da : db;
         pref = (exp_id == 0) ? 1 : 0;
         if ($urandom_range(0, 3) == 0) bus.uart_txrdy = 1'b0;
         bus.a_tx_data = da; bus.a_tx_valid = m[0];
         bus.b_tx_data = db; bus.b_tx_valid = m[1];
         #1;
         if (!bus.uart_txrdy) begin
            chk("rnd_txrdy_gate", {bus.a_tx_ready, bus.b_tx_ready}, 2'b00);
            repeat (2) @(negedge clk);
            bus.uart_txrdy = 1'b1;
            #1;
         end
         got_id = -1;
         for (int i = 0; i < 8 && got_id < 0; i++) begin
            if (bus.a_tx_ready || bus.b_tx_ready) got_id = bus.a_tx_ready ? 0 : 1;
            else begin @(negedge clk); #1; end
         end
         chk("rnd_both_ready", bus.a_tx_ready & bus.b_tx_ready, 1'b0);
         chk("rnd_grant", got_id, exp_id);
         @(negedge clk);
         bus.a_tx_valid = 1'b0; bus.b_tx_valid = 1'b0;
         repeat (GAP + 2) @(negedge clk);
         chk("rnd_byte", wr_log[$], exp_byte);
      end

      // Directed read with exact strobe timing.
      do_reset();
      base = oen_cyc;
      bus.uart_data_out = 8'hC3; bus.uart_rxrdy = 1'b1;
      @(negedge clk); #1;
      chk("t3_oen0", bus.uart_oen, 1'b0);
      chk("t3_csn0", bus.uart_csn, 1'b0);
      chk("t3_wen0", bus.uart_wen, 1'b1);
      bus.uart_rxrdy = 1'b0;
      @(negedge clk); #1;
      chk("t3_oen1", bus.uart_oen, 1'b0);
      chk("t3_valid_early", bus.rx_valid, 1'b0);
      @(negedge clk); #1;
      chk("t3_oen_off", bus.uart_oen, 1'b1);
      chk("t3_rx_valid", bus.rx_valid, 1'b1);
      chk("t3_rx_data", bus.rx_data, 8'hC3);
      chk("t3_oen_cycles", oen_cyc - base, RDC);
      rx_consume();

      // Random RX bytes with random consumer delay.
      for (int r = 0; r < 6; r++) begin
         exp_byte = 8'($urandom_range(0, 255));
         rx_once(exp_byte, got, ok);
         chk("rnd_rx_ok", ok, 1'b1);
         chk("rnd_rx_data", got, exp_byte);
         repeat ($urandom_range(0, 3)) @(negedge clk);
         chk("rnd_rx_hold", bus.rx_valid, 1'b1);
         rx_consume();
      end

      // Held RX register blocks servicing; core overflow gets latched.
      rx_once(8'h3C, got, ok);
      chk("t4_first", got, 8'h3C);
      base = oen_cyc;
      bus.uart_data_out = 8'h99; bus.uart_rxrdy = 1'b1;
      repeat (6) @(negedge clk);
      chk("t4_no_oen", oen_cyc - base, 0);
      chk("t4_rx_data_held", bus.rx_data, 8'h3C);
      bus.uart_overflow = 1'b1;
      @(negedge clk);
      bus.uart_overflow = 1'b0;
      #1;
      chk("t4_err_ovf", bus.err_flags, 3'b001);
      bus.rx_ready = 1'b1;
      @(negedge clk);
      bus.rx_ready = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 12 && !ok; i++) begin
         @(negedge clk); #1;
         if (!bus.uart_oen) bus.uart_rxrdy = 1'b0;
         if (bus.rx_valid) ok = 1'b1;
      end
      bus.uart_rxrdy = 1'b0;
      chk("t4_second", bus.rx_data, 8'h99);
      chk("t4_err_sticky", bus.err_flags, 3'b001);
      rx_consume();
      bus.err_clr = 1'b1;
      @(negedge clk);
      bus.err_clr = 1'b0;
      #1;
      chk("t4_err_clr", bus.err_flags, 3'b000);

      // Read and write requested together: read first, write right after.
      base = wr_log.size();
      rd_idx = -1; rdy_idx = -1;
      bus.uart_txrdy = 1'b1;
      bus.uart_data_out = 8'h47; bus.uart_rxrdy = 1'b1;
      bus.a_tx_data = 8'h6E; bus.a_tx_valid = 1'b1;
      #1;
      chk("t5_rd_priority", bus.a_tx_ready, 1'b0);
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (rdy_idx >= 0) bus.a_tx_valid = 1'b0;
         #1;
         if (!bus.uart_oen) begin
            if (rd_idx < 0) rd_idx = i;
            bus.uart_rxrdy = 1'b0;
         end
         if (bus.a_tx_ready && rdy_idx < 0) rdy_idx = i;
      end
      bus.a_tx_valid = 1'b0;
      chk("t5_rd_idx", rd_idx, 1);
      chk("t5_wr_idx", rdy_idx, RDC + 1);
      chk("t5_rx_data", bus.rx_data, 8'h47);
      chk("t5_wr_byte", wr_log[$], 8'h6E);
      chk("t5_wr_count", wr_log.size() - base, 1);
      rx_consume();

      // Reset in WR_STB: strobes, RX and error state drop immediately.
      rx_once(8'h81, got, ok);
      bus.uart_framing_err = 1'b1;
      @(negedge clk);
      bus.uart_framing_err = 1'b0;
      #1;
      chk("t6_frm_set", bus.err_flags, 3'b100);
      bus.a_tx_data = 8'hEE; bus.a_tx_valid = 1'b1;
      @(negedge clk);
      bus.a_tx_valid = 1'b0;
      #1;
      chk("t6_in_wr_stb", bus.uart_wen, 1'b0);
      rst = 1'b1;
      #1;
      chk("t6_wr_wen", bus.uart_wen, 1'b1);
      chk("t6_wr_csn", bus.uart_csn, 1'b1);
      chk("t6_wr_rx_valid", bus.rx_valid, 1'b0);
      chk("t6_wr_err", bus.err_flags, 3'b000);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Reset in RD_STB.
      bus.uart_data_out = 8'h55; bus.uart_rxrdy = 1'b1;
      @(negedge clk); #1;
      chk("t6_in_rd_stb", bus.uart_oen, 1'b0);
      rst = 1'b1;
      #1;
      chk("t6_rd_oen", bus.uart_oen, 1'b1);
      chk("t6_rd_csn", bus.uart_csn, 1'b1);
      chk("t6_rd_rx_valid", bus.rx_valid, 1'b0);
      bus.uart_rxrdy = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Set beats clear in the same cycle.
      bus.uart_parity_err = 1'b1; bus.err_clr = 1'b1;
      @(negedge clk);
      bus.uart_parity_err = 1'b0; bus.err_clr = 1'b0;
      #1;
      chk("t6_par_vs_clr", bus.err_flags, 3'b010);

      chk("strobe_rules", strobe_bad, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
